// File: rtl/seek_sched.sv
// seek_sched: head-positioning scheduler in front of the drive mechanical controller.
// It accepts seek/recalibrate commands over valid/ready, produces timed step_n/dir_sel
// sequences, tracks the logical cylinder, and strobes done after head settle.
module seek_sched #(
    parameter int TRK_W      = 7,
    parameter int NUM_TRACKS = 80,
    parameter int PULSE_CYC  = 16,
    parameter int RATE_CYC   = 300000,
    parameter int SETTLE_CYC = 750000,
    parameter int RECAL_MAX  = 85
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_recal,
    input  logic [TRK_W-1:0] cmd_track,
    input  logic             track_0,
    output logic             step_n,
    output logic             dir_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [TRK_W-1:0] cur_track,
    output logic             calibrated
);

    // One timer serves the pulse, gap and settle phases, so it is sized for the longest.
    localparam int TMR_MAX = (RATE_CYC > SETTLE_CYC) ? RATE_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = $clog2(RECAL_MAX + 1);

    localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(RATE_CYC - PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RECAL_LIM   = CNT_W'(RECAL_MAX);
    // One extra bit so a track count equal to 2**TRK_W still compares correctly.
    localparam logic [TRK_W:0]   TRK_LIMIT   = (TRK_W + 1)'(NUM_TRACKS);
    localparam logic [TRK_W-1:0] TRK_TOP     = {TRK_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PULSE,
        GAP,
        SETTLE,
        FINISH
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   step_cnt;   // outward steps issued by the current recalibrate
    logic               stepped;    // at least one step issued by the current command
    logic               recal_q;
    logic [TRK_W-1:0]   target_q;

    // Command sequencer: state, timing and every registered output.
    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // values from before this edge; a later assignment to the same register wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            step_cnt   <= '0;
            stepped    <= 1'b0;
            recal_q    <= 1'b0;
            target_q   <= '0;
            cmd_ready  <= 1'b1;
            step_n     <= 1'b1;
            dir_sel    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cur_track  <= '0;
            calibrated <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        recal_q   <= cmd_recal;
                        target_q  <= cmd_track;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        step_cnt  <= '0;
                        stepped   <= 1'b0;
                        // Direction is set here so it has settled for a full CHECK
                        // cycle before the first step_n falling edge.
                        dir_sel   <= cmd_recal | (cmd_track < cur_track);
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    timer <= '0;
                    if (recal_q) begin
                        if (track_0) begin
                            cur_track  <= '0;
                            calibrated <= 1'b1;
                            if (stepped) begin
                                state <= SETTLE;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        end else if (step_cnt == RECAL_LIM) begin
                            err        <= 1'b1;
                            calibrated <= 1'b0;
                            state      <= FINISH;
                            done       <= 1'b1;
                        end else begin
                            dir_sel <= 1'b1;
                            step_n  <= 1'b0;
                            state   <= PULSE;
                        end
                    end else begin
                        if (!calibrated || ({1'b0, target_q} >= TRK_LIMIT)) begin
                            err   <= 1'b1;
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (target_q == cur_track) begin
                            if (stepped) begin
                                state <= SETTLE;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        end else begin
                            dir_sel <= (target_q < cur_track);
                            step_n  <= 1'b0;
                            state   <= PULSE;
                        end
                    end
                end

                PULSE: begin
                    if (timer == PULSE_LAST) begin
                        step_n  <= 1'b1;
                        timer   <= '0;
                        stepped <= 1'b1;
                        state   <= GAP;
                        if (recal_q) begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                        // Saturate at both ends so the logical track never wraps.
                        if (dir_sel) begin
                            cur_track <= (cur_track == '0) ? '0 : cur_track - TRK_W'(1);
                        end else begin
                            cur_track <= (cur_track == TRK_TOP) ? TRK_TOP : cur_track + TRK_W'(1);
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                GAP: begin
                    if (timer == GAP_LAST) begin
                        state <= CHECK;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                FINISH: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
